// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap/mret sequencer in front of the CSR file.
// Accepts an exception, an enabled interrupt or mret while idle, then walks
// the CSR port (mepc, mcause, mstatus, mtvec / mepc) and ends with a single
// redirect pulse to fetch. busy_o stalls the pipeline for the whole sequence.
// Optional build macro: TRAP_VECTORED_EN enables vectored interrupt targets
// (mtvec mode 01 adds cause*4 for interrupts only).
module trap_ctrl #(
    parameter int CSR_AW = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              exc_valid_i,
    input  logic [3:0]        exc_cause_i,
    input  logic [XLEN-1:0]   exc_pc_i,
    input  logic              irq_i,
    input  logic              irq_en_i,
    input  logic [3:0]        irq_cause_i,
    input  logic              mret_i,
    output logic              busy_o,
    output logic              redirect_valid_o,
    output logic [XLEN-1:0]   redirect_pc_o,
    output logic [CSR_AW-1:0] csr_addr_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    output logic              csr_we_o,
    output logic              csr_re_o,
    output logic              csr_except_o,
    input  logic [XLEN-1:0]   csr_rdata_i
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_EPC,
        S_W_CAUSE,
        S_R_STAT0,
        S_R_STAT1,
        S_W_STAT,
        S_R_TVEC0,
        S_R_TVEC1,
        S_R_EPC0,
        S_R_EPC1,
        S_REDIR
    } state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   cause_q, cause_d;
    logic              is_mret_q, is_mret_d;
    logic [XLEN-1:0]   st_q, st_d;
    logic              busy_q, busy_d;
    logic              redir_q, redir_d;
    logic [XLEN-1:0]   rpc_q, rpc_d;
    logic [CSR_AW-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              exc_q, exc_d;

    // 12-bit CSR code zero-extended onto the CSR address port
    function automatic logic [CSR_AW-1:0] csr_addr(input logic [11:0] code);
        return {{(CSR_AW-12){1'b0}}, code};
    endfunction

    // Trap entry: MPIE <= MIE, MIE <= 0
    function automatic logic [XLEN-1:0] mstatus_trap(input logic [XLEN-1:0] st);
        logic [XLEN-1:0] r;
        r    = st;
        r[7] = st[3];
        r[3] = 1'b0;
        return r;
    endfunction

    // Trap return: MIE <= MPIE, MPIE <= 1
    function automatic logic [XLEN-1:0] mstatus_mret(input logic [XLEN-1:0] st);
        logic [XLEN-1:0] r;
        r    = st;
        r[3] = st[7];
        r[7] = 1'b1;
        return r;
    endfunction

`ifdef TRAP_VECTORED_EN
    // Vectored mode applies to interrupts only; exceptions use the base
    function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] tv,
                                                    input logic            is_irq,
                                                    input logic [3:0]      code);
        logic [XLEN-1:0] base;
        base = tv & ALIGN_MASK;
        if (tv[1:0] == 2'b01 && is_irq)
            return base + {{(XLEN-6){1'b0}}, code, 2'b00};
        return base;
    endfunction
`else
    // Direct mode only: mtvec mode bits are ignored
    function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] tv);
        return tv & ALIGN_MASK;
    endfunction
`endif

    // Next-state, latch and registered-output computation
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cause_d   = cause_q;
        is_mret_d = is_mret_q;
        st_d      = st_q;
        rpc_d     = rpc_q;
        redir_d   = 1'b0;
        addr_d    = '0;
        wdata_d   = '0;
        we_d      = 1'b0;
        re_d      = 1'b0;
        exc_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (exc_valid_i) begin
                    pc_d      = exc_pc_i & ALIGN_MASK;
                    cause_d   = {{(XLEN-4){1'b0}}, exc_cause_i};
                    is_mret_d = 1'b0;
                    state_d   = S_W_EPC;
                end else if (irq_i && irq_en_i) begin
                    pc_d      = exc_pc_i & ALIGN_MASK;
                    cause_d   = {1'b1, {(XLEN-5){1'b0}}, irq_cause_i};
                    is_mret_d = 1'b0;
                    state_d   = S_W_EPC;
                end else if (mret_i) begin
                    is_mret_d = 1'b1;
                    state_d   = S_R_STAT0;
                end
            end
            S_W_EPC:   state_d = S_W_CAUSE;
            S_W_CAUSE: state_d = S_R_STAT0;
            S_R_STAT0: state_d = S_R_STAT1;
            S_R_STAT1: begin
                // read data for mstatus is on the port this cycle
                st_d    = csr_rdata_i;
                state_d = S_W_STAT;
            end
            S_W_STAT:  state_d = is_mret_q ? S_R_EPC0 : S_R_TVEC0;
            S_R_TVEC0: state_d = S_R_TVEC1;
            S_R_TVEC1: begin
`ifdef TRAP_VECTORED_EN
                rpc_d = trap_target(csr_rdata_i, cause_q[XLEN-1], cause_q[3:0]);
`else
                rpc_d = trap_target(csr_rdata_i);
`endif
                state_d = S_REDIR;
            end
            S_R_EPC0:  state_d = S_R_EPC1;
            S_R_EPC1: begin
                rpc_d   = csr_rdata_i & ALIGN_MASK;
                state_d = S_REDIR;
            end
            S_REDIR:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they land registered
        // in the same cycle the state does.
        case (state_d)
            S_W_EPC: begin
                we_d = 1'b1; exc_d = 1'b1;
                addr_d = csr_addr(CSR_MEPC); wdata_d = pc_d;
            end
            S_W_CAUSE: begin
                we_d = 1'b1; exc_d = 1'b1;
                addr_d = csr_addr(CSR_MCAUSE); wdata_d = cause_d;
            end
            S_R_STAT0: begin re_d = 1'b1; addr_d = csr_addr(CSR_MSTATUS); end
            S_R_STAT1: addr_d = csr_addr(CSR_MSTATUS);
            S_W_STAT: begin
                we_d = 1'b1; exc_d = 1'b1;
                addr_d  = csr_addr(CSR_MSTATUS);
                wdata_d = is_mret_d ? mstatus_mret(st_d) : mstatus_trap(st_d);
            end
            S_R_TVEC0: begin re_d = 1'b1; addr_d = csr_addr(CSR_MTVEC); end
            S_R_TVEC1: addr_d = csr_addr(CSR_MTVEC);
            S_R_EPC0:  begin re_d = 1'b1; addr_d = csr_addr(CSR_MEPC); end
            S_R_EPC1:  addr_d = csr_addr(CSR_MEPC);
            S_REDIR:   redir_d = 1'b1;
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, latches and output registers; reset drops any sequence in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            cause_q   <= '0;
            is_mret_q <= 1'b0;
            st_q      <= '0;
            busy_q    <= 1'b0;
            redir_q   <= 1'b0;
            rpc_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            exc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cause_q   <= cause_d;
            is_mret_q <= is_mret_d;
            st_q      <= st_d;
            busy_q    <= busy_d;
            redir_q   <= redir_d;
            rpc_q     <= rpc_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            re_q      <= re_d;
            exc_q     <= exc_d;
        end
    end

    assign busy_o           = busy_q;
    assign redirect_valid_o = redir_q;
    assign redirect_pc_o    = rpc_q;
    assign csr_addr_o       = addr_q;
    assign csr_wdata_o      = wdata_q;
    assign csr_we_o         = we_q;
    assign csr_re_o         = re_q;
    assign csr_except_o     = exc_q;

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer that sits directly in front of the CSR register file (`scr1`). It accepts synchronous exceptions, external interrupts and `mret` from the core pipeline. It sequences the required CSR accesses (mepc, mcause, mstatus, mtvec) over the CSR file's address/data port. It then issues a single-cycle PC redirect to fetch, and stalls the pipeline for the whole sequence.

## Interface
Parameters:
- `CSR_AW`, 32: CSR address width, matching the CSR file port.
- `XLEN`, 32: data width.

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `exc_valid_i`  in  1  synchronous exception request.
- `exc_cause_i`  in  4  exception code (0–15).
- `exc_pc_i`  in  32  PC of faulting instruction, or PC of next instruction for an interrupt.
- `irq_i`  in  1  external interrupt request (level).
- `irq_en_i`  in  1  interrupts globally enabled (mstatus.MIE, as seen by the core).
- `irq_cause_i`  in  4  interrupt code.
- `mret_i`  in  1  mret retiring.
- `busy_o`  out  1  sequencer active; the pipeline must stall.
- `redirect_valid_o`  out  1  one-cycle redirect pulse.
- `redirect_pc_o`  out  32  redirect target; held between pulses.
- `csr_addr_o`  out  32  CSR address (12-bit code, zero-extended).
- `csr_wdata_o`  out  32  CSR write data.
- `csr_we_o`  out  1  CSR write strobe.
- `csr_re_o`  out  1  CSR read strobe.
- `csr_except_o`  out  1  drives the CSR file's `en_except`.
- `csr_rdata_i`  in  32  CSR read data, valid the cycle after `csr_re_o`.

## Operation
Request sampling:
- Requests are sampled only in IDLE. Priority is `exc_valid_i` > (`irq_i` & `irq_en_i`) > `mret_i`.
- Requests arriving while `busy_o`=1 are ignored. The core holds the condition until a redirect occurs.
- On accept, the block latches:
  - pc: `exc_pc_i` with bits [1:0] cleared.
  - cause: exception gives {28'b0, `exc_cause_i`}; interrupt gives {1'b1, 27'b0, `irq_cause_i`}.
  - kind: trap or mret.

CSR port cycle types:
- Write cycle: `csr_we_o`=1, `csr_except_o`=1, address and data driven.
- Read cycle: `csr_re_o`=1, `csr_except_o`=0, address driven. Data is captured the next cycle, with the address held and `csr_re_o`=0.
- Idle cycle: all strobes 0, address 0, wdata 0.

Trap path (FSM):
- IDLE → W_EPC: write 0x341 ← pc.
- → W_CAUSE: write 0x342 ← cause.
- → R_STAT: 2 cycles, read 0x300 → st.
- → W_STAT: write 0x300 ← st with bit7 (MPIE) = st[3] and bit3 (MIE) = 0.
- → R_TVEC: 2 cycles, read 0x305 → tv.
- → REDIR.
- → IDLE.

Mret path:
- IDLE → R_STAT: 2 cycles.
- → W_STAT: write st with bit3 = st[7] and bit7 = 1.
- → R_EPC: 2 cycles, read 0x341 → ep.
- → REDIR.
- → IDLE.

Redirect target:
- Trap: {tv[31:2], 2'b00}, subject to the vectored option under Configuration.
- Mret: {ep[31:2], 2'b00}.
- 32-bit wrap-around arithmetic; no overflow detection.

REDIR state: `redirect_valid_o`=1 for exactly one cycle, with `redirect_pc_o` updated in the same cycle.

## Timing
- Reset values: `busy_o`=0, `redirect_valid_o`=0, `redirect_pc_o`=0, all CSR outputs 0, state IDLE, latches 0.
- Reset mid-sequence: next cycle is IDLE with reset values. The partial CSR update is not rolled back and the request is dropped.
- `busy_o` rises the cycle after accept and falls the cycle after REDIR. The block returns to IDLE and can accept a new request the following cycle.
- Trap latency: accept edge to `redirect_valid_o` is 8 cycles (W_EPC 1, W_CAUSE 1, R_STAT 2, W_STAT 1, R_TVEC 2, REDIR 1).
- Mret latency: 6 cycles.
- Simultaneous requests in IDLE: the priority rule applies; losers are not queued.
- `irq_i` deasserting after accept has no effect on the sequence.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `TRAP_VECTORED_EN` defined:
  - If tv[1:0]==2'b01 and the latched cause[31]==1, target = {tv[31:2],2'b00} + (cause[3:0] << 2).
  - Exceptions always use the base address.
- `TRAP_VECTORED_EN` undefined: tv[1:0] is ignored and all traps use {tv[31:2],2'b00}.

## Test plan
- Exception: cause=2, pc=0x0000_1006, mtvec=0x8000_0100, mstatus=0x8.
  → mepc=0x1004, mcause=0x2, mstatus=0x80, redirect 0x8000_0100 at cycle 8.
- Interrupt: irq_en_i=1, irq_cause_i=11, mtvec=0x8000_0101.
  → mcause=0x8000_000B; redirect 0x8000_012C with `TRAP_VECTORED_EN` defined, 0x8000_0100 without it.
- Mret: mepc=0x0000_2000, mstatus=0x80.
  → mstatus=0x88, redirect 0x2000 at cycle 6, `csr_except_o` high only in W_STAT.
- Simultaneous `exc_valid_i`, `irq_i` and `mret_i` in IDLE.
  → exception path taken, mcause[31]=0; a second `exc_valid_i` during busy is ignored.
- `rst_i` asserted in R_TVEC.
  → next cycle all outputs 0, no redirect pulse; a fresh exception afterwards completes in 8 cycles.
- `irq_i`=1 with `irq_en_i`=0.
  → no accept, `busy_o` stays 0, no CSR strobes.
